// File: rtl/cond_exec_stage.sv
// Execute-stage NZCV flags register and conditional-execution gate.
// Gates side effects and flag writes with the external checker decision and registers the result into EX/MEM.
module cond_exec_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_alu_flags,
  input  logic [1:0]        in_flag_write,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic              in_pc_src,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_W-1:0]  in_rd,
  output logic [3:0]        cond_code,
  output logic [3:0]        nzcv,
  input  logic              cond_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic              out_pc_src,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_W-1:0]  out_rd,
  output logic [15:0]       squash_count
);

  logic              accept;
  logic              exe_acc;
  logic              squash_acc;

  logic [3:0]        nzcv_q, nzcv_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              regw_q, regw_d;
  logic              memw_q, memw_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  rd_q, rd_d;

  // Flush blocks acceptance, so flag and counter updates keyed on accept never see a flushed instruction.
  assign in_ready   = !flush && (!valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign exe_acc    = accept && cond_ex;
  assign squash_acc = accept && !cond_ex;

  assign cond_code = in_cond;
  assign nzcv      = nzcv_q;

  always_comb begin
    nzcv_d = nzcv_q;
    if (exe_acc) begin
      if (in_flag_write[1]) nzcv_d[3:2] = in_alu_flags[3:2];
      if (in_flag_write[0]) nzcv_d[1:0] = in_alu_flags[1:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (squash_acc && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    valid_d = valid_q;
    regw_d  = regw_q;
    memw_d  = memw_q;
    pcsrc_d = pcsrc_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      regw_d  = 1'b0;
      memw_d  = 1'b0;
      pcsrc_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      regw_d  = in_reg_write && cond_ex;
      memw_d  = in_mem_write && cond_ex;
      pcsrc_d = in_pc_src && cond_ex;
      alu_d   = in_alu_result;
      wdata_d = in_write_data;
      rd_d    = in_rd;
    end else if (out_ready) begin
      // Slot drains: controls clear, data is left as-is.
      valid_d = 1'b0;
      regw_d  = 1'b0;
      memw_d  = 1'b0;
      pcsrc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      regw_q  <= 1'b0;
      memw_q  <= 1'b0;
      pcsrc_q <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      nzcv_q  <= nzcv_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      regw_q  <= regw_d;
      memw_q  <= memw_d;
      pcsrc_q <= pcsrc_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_reg_write  = regw_q;
  assign out_mem_write  = memw_q;
  assign out_pc_src     = pcsrc_q;
  assign out_alu_result = alu_q;
  assign out_write_data = wdata_q;
  assign out_rd         = rd_q;
  assign squash_count   = cnt_q;

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage flags register and conditional-execution gate for the ARM pipeline. It holds the architectural NZCV flags and presents them, with the current instruction's condition field, to the combinational condition checker. It consumes the checker's execute decision, gates the instruction's side effects and flag update with it, and registers the result into the execute/memory pipeline register with valid/ready handshaking, stall and flush.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_W, 4, width of destination register index

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of the stage, highest priority
- in_valid  in  1  upstream instruction present
- in_ready  out  1  stage can accept this cycle
- in_cond  in  4  instruction condition field [31:28]
- in_alu_flags  in  4  ALU flags {N,Z,C,V} of this instruction
- in_flag_write  in  2  bit1: update N,Z; bit0: update C,V
- in_reg_write, in_mem_write, in_pc_src  in  1 each  ungated side-effect controls
- in_alu_result  in  DATA_W  ALU result
- in_write_data  in  DATA_W  store data
- in_rd  in  REG_W  destination register
- cond_code  out  4  to condition checker, equals in_cond (combinational)
- nzcv  out  4  to condition checker, registered flags {N,Z,C,V}
- cond_ex  in  1  checker decision for (cond_code, nzcv), same cycle
- out_valid  out  1  memory-stage instruction present
- out_ready  in  1  memory stage accepts
- out_reg_write, out_mem_write, out_pc_src  out  1 each  gated controls
- out_alu_result, out_write_data  out  DATA_W  registered data
- out_rd  out  REG_W  registered destination
- squash_count  out  16  saturating count of condition-failed instructions

## Operation
- in_ready = !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
- exe = cond_ex, sampled in the accept cycle only.
- On accept: out_valid<=1; data/rd registered unconditionally; out_reg_write<=in_reg_write&&exe, same for mem_write and pc_src. A failed instruction still advances as a valid slot with all three controls 0.
- Flag update on accept&&exe only: in_flag_write[1] -> N,Z <= in_alu_flags[3:2]; in_flag_write[0] -> C,V <= in_alu_flags[1:0]; unselected bits hold.
- squash_count += 1 on accept&&!exe; saturates at 16'hFFFF.
- No accept, out_ready=1: out_valid<=0, control outputs <=0, data holds.
- No accept, out_ready=0, out_valid=1: all outputs hold (stall).
- flush=1: out_valid<=0, control outputs<=0; no flag update; no count change; in_ready=0.
- Reset (async, any time): nzcv=0000, out_valid=0, all control outputs 0, out_alu_result/out_write_data/out_rd=0, squash_count=0. in_ready=1 after release, assuming flush=0.

## Timing
- One-cycle latency: instruction accepted in cycle t is on out_* in cycle t+1.
- Flags written at t are visible on nzcv at t+1. Back-to-back flag-setting and conditional instructions need no forwarding or bubble.
- cond_code->cond_ex is a combinational loop-free path through the external checker. nzcv is a register output only.
- A stalled upstream instruction, in_valid=1 and in_ready=0, never updates flags or the counter, whatever cond_ex does.
- Flush and accept cannot coincide, because in_ready is 0 during flush.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 and nzcv=1111 -> immediately nzcv=0000, out_valid=0, squash_count=0; after release in_ready=1.
- Flag set then use: accept cond=1110, flag_write=11, alu_flags=0100 -> next cycle nzcv=0100. Then accept cond=0000, reg_write=1 with checker returning 1 -> out_reg_write=1, out_valid=1.
- Partial write: nzcv=0101, accept flag_write=10, alu_flags=1011, exe=1 -> nzcv=1001.
- Squash: nzcv=0100, cond=0001, cond_ex=0, reg_write=mem_write=pc_src=1, flag_write=11 -> out_valid=1, all controls 0, nzcv stays 0100, squash_count increments by 1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, nzcv and counter unchanged. out_ready=1 -> the held instruction is accepted that cycle.
- Flush: flush=1 with in_valid=1, flag_write=11, exe=1 -> in_ready=0, next cycle out_valid=0, nzcv and squash_count unchanged. Separately, 65536 squashes leave squash_count=16'hFFFF.
